// File: rtl/mux4_pkg.sv
// Shared select codes and types for the 4:1 selector family.
// No logic of its own; latency and backpressure do not apply.
// Imported by mux4_comb and mux4_bit.
package mux4_pkg;

  typedef logic [1:0] mux4_sel_t;

  localparam mux4_sel_t SEL_A = 2'b00;
  localparam mux4_sel_t SEL_B = 2'b01;
  localparam mux4_sel_t SEL_C = 2'b10;
  localparam mux4_sel_t SEL_D = 2'b11;

endpackage : mux4_pkg

// File: rtl/mux4_comb.sv
// Purely combinational 4:1 selector: y follows the input named by s.
// Latency: zero (no state).
// Backpressure: none; a new selection is valid on every input change.
module mux4_comb
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  mux4_sel_t        s,
  output logic [WIDTH-1:0] y
);

  // Full, parallel decode of s; every code is covered so nothing is latched.
  always_comb begin
    y = d;
    case (s)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      default: y = d;
    endcase
  end

endmodule : mux4_comb

// File: rtl/mux4_bit.sv
// 4:1 selector with an optional output register (REG_OUT).
// Latency: 1 cycle when REG_OUT = 1, zero when REG_OUT = 0.
// Backpressure: none; accepts new inputs every cycle.
module mux4_bit
  import mux4_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter bit               REG_OUT = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  mux4_sel_t        s,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] sel;

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .s (s),
    .y (sel)
  );

  if (REG_OUT) begin : g_reg
    // Register the selection; reset wins over data on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        y <= RST_VAL;
      end else begin
        y <= sel;
      end
    end
  end else begin : g_comb
    // Combinational variant: clock and reset play no part in the datapath.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign y = sel;
  end

endmodule : mux4_bit

// File: tb/tb_mux4_bit.sv
// Randomized/directed bench with a queue scoreboard for three configurations:
// 1-bit registered, 8-bit registered with non-zero reset value, 8-bit combinational.
// Expected values come from an array-indexing reference model.
module tb_mux4_bit;

  localparam logic [7:0] RV8 = 8'h5A;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a1, b1, c1, d1;
  logic [1:0] s1;
  logic       y1;

  logic [7:0] a8, b8, c8, d8, y8;
  logic [1:0] s8;

  logic [7:0] ac, bc, cc, dc, yc;
  logic [1:0] sc;

  exp_t q1[$];
  exp_t q8[$];
  exp_t qc[$];
  event comb_ev;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_bit #(.WIDTH(1), .REG_OUT(1'b1), .RST_VAL(1'b0)) u_dut1 (
    .clk (clk), .rst (rst), .a (a1), .b (b1), .c (c1), .d (d1), .s (s1), .y (y1)
  );

  mux4_bit #(.WIDTH(8), .REG_OUT(1'b1), .RST_VAL(RV8)) u_dut8 (
    .clk (clk), .rst (rst), .a (a8), .b (b8), .c (c8), .d (d8), .s (s8), .y (y8)
  );

  mux4_bit #(.WIDTH(8), .REG_OUT(1'b0)) u_dutc (
    .clk (clk), .rst (rst), .a (ac), .b (bc), .c (cc), .d (dc), .s (sc), .y (yc)
  );

  // Reference model: the select code is simply an index into the four sources.
  function automatic logic [7:0] ref_pick(input logic [1:0] sv, input logic [7:0] av,
                                          input logic [7:0] bv, input logic [7:0] cv,
                                          input logic [7:0] dv);
    logic [7:0] src [4];
    src[0] = av; src[1] = bv; src[2] = cv; src[3] = dv;
    return src[sv];
  endfunction

  task automatic compare(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one registered cycle: narrow inputs from the caller, wide inputs random.
  task automatic drive(input string name, input logic r, input logic [1:0] sv,
                       input logic av, input logic bv, input logic cv, input logic dv);
    exp_t e;
    @(negedge clk);
    rst = r;
    s1 = sv; a1 = av; b1 = bv; c1 = cv; d1 = dv;
    s8 = 2'($urandom_range(0, 3));
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
    e.name = name;
    e.val  = r ? 8'h00 : ref_pick(sv, {7'd0, av}, {7'd0, bv}, {7'd0, cv}, {7'd0, dv});
    q1.push_back(e);
    e.name = {name, "_w8"};
    e.val  = r ? RV8 : ref_pick(s8, a8, b8, c8, d8);
    q8.push_back(e);
    @(posedge clk);
  endtask

  // Drive the combinational instance and announce a pending check.
  task automatic drive_comb(input string name, input logic [1:0] sv, input logic [7:0] av,
                            input logic [7:0] bv, input logic [7:0] cv, input logic [7:0] dv);
    exp_t e;
    sc = sv; ac = av; bc = bv; cc = cv; dc = dv;
    e.name = name;
    e.val  = ref_pick(sv, av, bv, cv, dv);
    qc.push_back(e);
    -> comb_ev;
    #3;
  endtask

  // Registered monitor: one output per clock, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare(e.name, {7'd0, y1}, e.val);
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      compare(e.name, y8, e.val);
    end
  end

  // Combinational monitor: checks shortly after each input change.
  initial begin
    exp_t e;
    forever begin
      @(comb_ev);
      #1;
      if (qc.size() > 0) begin
        e = qc.pop_front();
        compare(e.name, yc, e.val);
      end
    end
  end

  initial begin
    s1 = 2'b11; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
    s8 = 2'b00; a8 = '0; b8 = '0; c8 = '0; d8 = '0;
    sc = 2'b00; ac = '0; bc = '0; cc = '0; dc = '0;

    // Reset held two cycles with all inputs high.
    drive("reset0", 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    drive("reset1", 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);

    // One-hot walk.
    drive("walk_a",   1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("walk_b",   1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    drive("walk_c",   1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("walk_d",   1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    drive("walk_off", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Non-selected isolation: only the selected source is 0.
    for (int k = 0; k < 4; k++) begin
      logic [3:0] v;
      v = 4'b1111;
      v[k] = 1'b0;
      drive($sformatf("iso_s%0d", k), 1'b0, 2'(k), v[0], v[1], v[2], v[3]);
    end

    // Reset mid-operation.
    drive("mid_set",  1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("mid_rst",  1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    drive("mid_rel",  1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);

    // Exhaustive over {s, a, b, c, d}.
    for (int n = 0; n < 64; n++) begin
      logic [5:0] v;
      v = 6'(n);
      drive("exh", 1'b0, v[5:4], v[3], v[2], v[1], v[0]);
    end

    // Random traffic with occasional reset.
    for (int n = 0; n < 200; n++) begin
      logic [5:0] v;
      v = 6'($urandom);
      drive("rand", ($urandom_range(0, 15) == 0), v[5:4], v[3], v[2], v[1], v[0]);
    end

    // Let the registered scoreboards drain, bounded.
    rst = 1'b0;
    for (int t = 0; t < 10 && (q1.size() > 0 || q8.size() > 0); t++) @(posedge clk);
    #2;
    checks++;
    if (q1.size() != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q1.size() + q8.size());
    end

    // Combinational sweep, then rst toggling, then random.
    for (int k = 0; k < 4; k++)
      drive_comb($sformatf("comb_s%0d", k), 2'(k), 8'hA5, 8'h3C, 8'hF0, 8'h0F);
    rst = 1'b1;
    drive_comb("comb_rst_hi", 2'b10, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
    rst = 1'b0;
    drive_comb("comb_rst_lo", 2'b01, 8'hA5, 8'h3C, 8'hF0, 8'h0F);
    for (int n = 0; n < 50; n++) begin
      rst = 1'($urandom);
      drive_comb("comb_rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));
    end
    #5;
    checks++;
    if (qc.size() != 0) begin
      failures++;
      $display("FAIL comb_drain pending=%0d expected=0", qc.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux4_bit
